// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Constants shared by the pipeline back-end: data width and
//                the architectural register numbers with fixed roles.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int          XLEN     = 32;

  // Architectural register numbers with special meaning
  localparam logic [4:0]  REG_ZERO = 5'd0;   // hard-wired zero
  localparam logic [4:0]  REG_SP   = 5'd29;  // stack pointer
  localparam logic [4:0]  REG_RA   = 5'd31;  // return address

  // True when a register number names the hard-wired zero register
  function automatic logic isZeroReg(input logic [4:0] regNum);
    return (regNum == REG_ZERO);
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/wb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : wb_mux
//  Description : Writeback source select. Picks the memory read data for
//                loads, the ALU result otherwise. Purely combinational.
//  Ports       : i_memtoReg     1 = select memory data, 0 = select ALU result
//                i_aluResult    ALU result from MEM/WB
//                i_memReadData  data-memory read data from MEM/WB
//                o_wbData       selected writeback value
//  Revision    : 1.0  initial release
// ============================================================================
module wb_mux
  import cpu_pkg::*;
(
  input  logic            i_memtoReg,
  input  logic [XLEN-1:0] i_aluResult,
  input  logic [XLEN-1:0] i_memReadData,
  output logic [XLEN-1:0] o_wbData
);

  always_comb begin
    o_wbData = i_aluResult;
    if (i_memtoReg) begin
      o_wbData = i_memReadData;
    end
  end

endmodule : wb_mux
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : Writeback stage and architectural register file. Selects the
//                writeback value, commits it into the register file, serves
//                two combinational read ports with same-cycle write bypass and
//                keeps registered debug copies of the last committed write.
//  Ports       : Clk             system clock, rising-edge active
//                Reset_n         synchronous active-low reset
//                MemtoReg_in     1 = write memory data, 0 = write ALU result
//                RegWrite_in     write enable from MEM/WB
//                ALUResult_in    ALU result from MEM/WB
//                MemReadData_in  data-memory read data from MEM/WB
//                WriteReg_in     destination register from MEM/WB
//                ReadReg1/2      ID-stage read addresses
//                ReadData1/2     read data (combinational, bypassed)
//                WriteData_dbg   value of last committed write
//                WriteReg_dbg    destination of last committed write
//                WriteCount      committed writes since reset (wrapping)
//  Revision    : 1.0  initial release
// ============================================================================
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int          NREGS   = 32,
  parameter logic [31:0] SP_INIT = 32'h0000_03FC,
  parameter int          CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             MemtoReg_in,
  input  logic             RegWrite_in,
  input  logic [XLEN-1:0]  ALUResult_in,
  input  logic [XLEN-1:0]  MemReadData_in,
  input  logic [4:0]       WriteReg_in,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  output logic [XLEN-1:0]  ReadData1,
  output logic [XLEN-1:0]  ReadData2,
  output logic [XLEN-1:0]  WriteData_dbg,
  output logic [4:0]       WriteReg_dbg,
  output logic [CNT_W-1:0] WriteCount
);

  localparam int c_numReadPorts = 2;

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [XLEN-1:0]  r_writeDataDbg;
  logic [4:0]       r_writeRegDbg;
  logic [CNT_W-1:0] r_writeCount;

  logic [XLEN-1:0]  w_wbData;
  logic             w_commit;
  logic [4:0]       w_readAddr [c_numReadPorts];
  logic [XLEN-1:0]  w_readData [c_numReadPorts];

  // --------------------------------------------------------------------------
  // Writeback source select
  // --------------------------------------------------------------------------
  wb_mux u_wbMux (
    .i_memtoReg    (MemtoReg_in),
    .i_aluResult   (ALUResult_in),
    .i_memReadData (MemReadData_in),
    .o_wbData      (w_wbData)
  );

  // Reset gating the commit also kills the bypass while reset is held, so
  // readers see plain register contents during and right after reset.
  assign w_commit = RegWrite_in && !isZeroReg(WriteReg_in) && Reset_n;

  // --------------------------------------------------------------------------
  // Register array. r0 storage exists but is never written and never read.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end
    end else if (w_commit) begin
      r_regs[WriteReg_in] <= w_wbData;
    end
  end

  // --------------------------------------------------------------------------
  // Debug copies of the last committed write and the commit counter.
  // The counter wraps silently.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_writeDataDbg <= '0;
      r_writeRegDbg  <= '0;
      r_writeCount   <= '0;
    end else if (w_commit) begin
      r_writeDataDbg <= w_wbData;
      r_writeRegDbg  <= WriteReg_in;
      r_writeCount   <= r_writeCount + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports: zero register, then same-cycle bypass, then array contents.
  // The bypass makes a write visible in the cycle it is presented, as if the
  // array were written in the first half-cycle and read in the second.
  // --------------------------------------------------------------------------
  assign w_readAddr[0] = ReadReg1;
  assign w_readAddr[1] = ReadReg2;

  for (genvar p = 0; p < c_numReadPorts; p++) begin : g_readPort
    always_comb begin
      w_readData[p] = r_regs[w_readAddr[p]];
      if (isZeroReg(w_readAddr[p])) begin
        w_readData[p] = '0;
      end else if (w_commit && (w_readAddr[p] == WriteReg_in)) begin
        w_readData[p] = w_wbData;
      end
    end
  end

  assign ReadData1     = w_readData[0];
  assign ReadData2     = w_readData[1];
  assign WriteData_dbg = r_writeDataDbg;
  assign WriteReg_dbg  = r_writeRegDbg;
  assign WriteCount    = r_writeCount;

endmodule : wb_regfile
`default_nettype wire
